// File: rtl/flag_int_unit.sv
// flag_int_unit
//
// Consumer side of the ALU flag interface. It holds the carry/zero flags and
// the interrupt-enable flag, a LIFO shadow stack of {C,Z} for interrupt
// entry/return, and the synchronizer plus request logic for the external
// interrupt line.
//
// Parameters:
//   SYNC_STAGES  flops in the INTR synchronizer chain (>= 2)
//   SHAD_DEPTH   shadow {C,Z} entries = supported nesting depth (>= 1)
//
// Configuration macro:
//   INTR_LEVEL_EN  defined   -> level-sensitive interrupt: the request follows
//                               the synchronized INTR level, and INT_ACK does
//                               not clear it
//                  undefined -> rising-edge detect with a pending latch
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   C_IN, Z_IN          ALU carry-out / zero
//   FLG_C_LD/SET/CLR    carry flag load / set / clear
//   FLG_Z_LD            zero flag load
//   I_SET, I_CLR        interrupt-enable set / clear
//   RETI                pop the shadow stack into C/Z
//   INT_ACK             interrupt entry acknowledge from the control unit
//   INTR                external interrupt (asynchronous)
//   C_FLAG, Z_FLAG      flags (C_FLAG also feeds ALU CIN)
//   I_FLAG              interrupt enable
//   INT_REQ             interrupt request to the control unit
//   SHAD_CNT            occupied shadow entries
//   SHAD_OVF            sticky shadow-stack overflow

module flag_int_unit #(
    parameter int SYNC_STAGES = 2,
    parameter int SHAD_DEPTH  = 2
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            C_IN,
    input  logic                            Z_IN,
    input  logic                            FLG_C_LD,
    input  logic                            FLG_C_SET,
    input  logic                            FLG_C_CLR,
    input  logic                            FLG_Z_LD,
    input  logic                            I_SET,
    input  logic                            I_CLR,
    input  logic                            RETI,
    input  logic                            INT_ACK,
    input  logic                            INTR,
    output logic                            C_FLAG,
    output logic                            Z_FLAG,
    output logic                            I_FLAG,
    output logic                            INT_REQ,
    output logic [$clog2(SHAD_DEPTH+1)-1:0] SHAD_CNT,
    output logic                            SHAD_OVF
);

    localparam int                CNT_W     = $clog2(SHAD_DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(SHAD_DEPTH);
    localparam logic [CNT_W-1:0]  ONE_CNT   = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   intr_sync;
    logic                   pending;
    logic                   ack_acc;
    logic                   reti_act;

    logic [SHAD_DEPTH-1:0]  shad_c;
    logic [SHAD_DEPTH-1:0]  shad_z;
    logic                   shad_full;
    logic                   shad_empty;
    logic [CNT_W-1:0]       wr_idx;
    logic [CNT_W-1:0]       rd_idx;
    logic                   pop_c;
    logic                   pop_z;

    // ------------------------------------------------------------------
    // INTR synchronizer; sync_q[0] is the first flop after the pin.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], INTR};
        end
    end

    assign intr_sync = sync_q[SYNC_STAGES-1];

`ifdef INTR_LEVEL_EN
    // Level mode: the synchronized line itself is the pending condition.
    assign pending = intr_sync;
`else
    logic prev_q;
    logic pending_q;
    logic edge_det;

    assign edge_det = intr_sync & ~prev_q;

    // A fresh edge arriving in the acknowledge cycle must not be lost,
    // so set has priority over the acknowledge clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            prev_q <= intr_sync;
            if (edge_det) begin
                pending_q <= 1'b1;
            end else if (ack_acc) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign pending = pending_q;
`endif

    assign INT_REQ = pending & I_FLAG;

    // An acknowledge without a live request is ignored entirely, and an
    // accepted acknowledge masks any RETI in the same cycle.
    assign ack_acc  = INT_ACK & INT_REQ;
    assign reti_act = RETI & ~ack_acc;

    // ------------------------------------------------------------------
    // Shadow stack addressing. When full, a push overwrites the top entry.
    // ------------------------------------------------------------------
    assign shad_full  = (SHAD_CNT == DEPTH_CNT);
    assign shad_empty = (SHAD_CNT == '0);
    assign wr_idx     = shad_full ? (DEPTH_CNT - ONE_CNT) : SHAD_CNT;
    assign rd_idx     = SHAD_CNT - ONE_CNT;

    // Popping an empty stack yields zeros.
    always_comb begin
        pop_c = 1'b0;
        pop_z = 1'b0;
        for (int i = 0; i < SHAD_DEPTH; i++) begin
            if (!shad_empty && (rd_idx == CNT_W'(i))) begin
                pop_c = shad_c[i];
                pop_z = shad_z[i];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shad_c <= '0;
            shad_z <= '0;
        end else if (ack_acc) begin
            for (int i = 0; i < SHAD_DEPTH; i++) begin
                if (wr_idx == CNT_W'(i)) begin
                    shad_c[i] <= C_FLAG;
                    shad_z[i] <= Z_FLAG;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SHAD_CNT <= '0;
            SHAD_OVF <= 1'b0;
        end else if (ack_acc) begin
            if (shad_full) begin
                SHAD_OVF <= 1'b1;
            end else begin
                SHAD_CNT <= SHAD_CNT + ONE_CNT;
            end
        end else if (reti_act && !shad_empty) begin
            SHAD_CNT <= SHAD_CNT - ONE_CNT;
        end
    end

    // ------------------------------------------------------------------
    // Flags
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            C_FLAG <= 1'b0;
            Z_FLAG <= 1'b0;
        end else if (ack_acc) begin
            C_FLAG <= C_FLAG;
            Z_FLAG <= Z_FLAG;
        end else if (reti_act) begin
            C_FLAG <= pop_c;
            Z_FLAG <= pop_z;
        end else begin
            if (FLG_C_CLR) begin
                C_FLAG <= 1'b0;
            end else if (FLG_C_SET) begin
                C_FLAG <= 1'b1;
            end else if (FLG_C_LD) begin
                C_FLAG <= C_IN;
            end
            if (FLG_Z_LD) begin
                Z_FLAG <= Z_IN;
            end
        end
    end

    // I_SET/I_CLR act alongside RETI, giving RETIE/RETID.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            I_FLAG <= 1'b0;
        end else if (ack_acc) begin
            I_FLAG <= 1'b0;
        end else if (I_CLR) begin
            I_FLAG <= 1'b0;
        end else if (I_SET) begin
            I_FLAG <= 1'b1;
        end
    end

endmodule

// File: tb/tb_flag_int_unit.sv
// Testbench for flag_int_unit (default build: edge-detect, SYNC_STAGES=2,
// SHAD_DEPTH=2). Stimulus pushes hand-computed expected output snapshots into
// a scoreboard queue; a monitor on the falling clock edge pops and compares.

module tb_flag_int_unit;

    logic       CLK;
    logic       RST;
    logic       C_IN, Z_IN;
    logic       FLG_C_LD, FLG_C_SET, FLG_C_CLR, FLG_Z_LD;
    logic       I_SET, I_CLR, RETI, INT_ACK, INTR;
    logic       C_FLAG, Z_FLAG, I_FLAG, INT_REQ, SHAD_OVF;
    logic [1:0] SHAD_CNT;

    flag_int_unit #(.SYNC_STAGES(2), .SHAD_DEPTH(2)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .C_IN     (C_IN),
        .Z_IN     (Z_IN),
        .FLG_C_LD (FLG_C_LD),
        .FLG_C_SET(FLG_C_SET),
        .FLG_C_CLR(FLG_C_CLR),
        .FLG_Z_LD (FLG_Z_LD),
        .I_SET    (I_SET),
        .I_CLR    (I_CLR),
        .RETI     (RETI),
        .INT_ACK  (INT_ACK),
        .INTR     (INTR),
        .C_FLAG   (C_FLAG),
        .Z_FLAG   (Z_FLAG),
        .I_FLAG   (I_FLAG),
        .INT_REQ  (INT_REQ),
        .SHAD_CNT (SHAD_CNT),
        .SHAD_OVF (SHAD_OVF)
    );

    typedef struct {
        string      name;
        logic [6:0] v;     // {C, Z, I, REQ, CNT[1:0], OVF}
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    // Monitor
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [6:0] got;
            e   = sb.pop_front();
            got = {C_FLAG, Z_FLAG, I_FLAG, INT_REQ, SHAD_CNT, SHAD_OVF};
            checks++;
            if (got !== e.v) begin
                failures++;
                $display("FAIL %s: c/z/i/req/cnt/ovf got %b required %b", e.name, got, e.v);
            end
        end
    end

    task automatic chk(input string nm, input logic c, input logic z, input logic i,
                       input logic req, input logic [1:0] cnt, input logic ovf);
        exp_t e;
        e.name = nm;
        e.v    = {c, z, i, req, cnt, ovf};
        sb.push_back(e);
    endtask

    // Advance one active edge, then drop all single-cycle pulses.
    task automatic tick();
        @(posedge CLK);
        #1;
        FLG_C_LD  = 1'b0;
        FLG_C_SET = 1'b0;
        FLG_C_CLR = 1'b0;
        FLG_Z_LD  = 1'b0;
        I_SET     = 1'b0;
        I_CLR     = 1'b0;
        RETI      = 1'b0;
        INT_ACK   = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        C_IN = 0; Z_IN = 0; INTR = 0;
        FLG_C_LD = 0; FLG_C_SET = 0; FLG_C_CLR = 0; FLG_Z_LD = 0;
        I_SET = 0; I_CLR = 0; RETI = 0; INT_ACK = 0;

        tick(); tick();
        chk("reset", 0,0,0,0,2'd0,0);
        RST = 1'b0;

        // Flag loading and priority
        C_IN = 1; FLG_C_LD = 1;               tick(); chk("c_load",         1,0,0,0,2'd0,0);
        FLG_C_SET = 1; FLG_C_CLR = 1;         tick(); chk("c_clr_over_set", 0,0,0,0,2'd0,0);
        C_IN = 0; FLG_C_SET = 1; FLG_C_LD = 1; tick(); chk("c_set_over_ld", 1,0,0,0,2'd0,0);
        Z_IN = 1; FLG_Z_LD = 1;               tick(); chk("z_load",         1,1,0,0,2'd0,0);

        // Interrupt latency: edge 3 after INTR rises
        I_SET = 1;        tick(); chk("i_set",     1,1,1,0,2'd0,0);
        INTR = 1;         tick(); chk("lat_edge1", 1,1,1,0,2'd0,0);
                          tick(); chk("lat_edge2", 1,1,1,0,2'd0,0);
                          tick(); chk("lat_edge3", 1,1,1,1,2'd0,0);
        INTR = 0; INT_ACK = 1; tick(); chk("ack_entry", 1,1,0,0,2'd1,0);
        FLG_C_CLR = 1; Z_IN = 0; FLG_Z_LD = 1; tick(); chk("flags_in_isr", 0,0,0,0,2'd1,0);
        RETI = 1;         tick(); chk("reti_restore", 1,1,0,0,2'd0,0);

        // Masked interrupt keeps pending
        INTR = 1;         tick(); chk("masked_a",    1,1,0,0,2'd0,0);
        INTR = 0;         tick(); chk("masked_b",    1,1,0,0,2'd0,0);
                          tick(); chk("masked_c",    1,1,0,0,2'd0,0);
                          tick(); chk("masked_hold", 1,1,0,0,2'd0,0);
        I_SET = 1; FLG_Z_LD = 1; tick(); chk("masked_retained", 1,0,1,1,2'd0,0);
        INT_ACK = 1;      tick(); chk("push_10",     1,0,0,0,2'd1,0);

        // Acknowledge without request is ignored
        I_SET = 1;        tick(); chk("i_set2",      1,0,1,0,2'd1,0);
        INT_ACK = 1;      tick(); chk("ack_ignored", 1,0,1,0,2'd1,0);
        FLG_C_CLR = 1; Z_IN = 1; FLG_Z_LD = 1; tick(); chk("flags_01", 0,1,1,0,2'd1,0);

        // New edge coincident with an accepted acknowledge
        INTR = 1;         tick(); chk("sim_a", 0,1,1,0,2'd1,0);
        INTR = 0;         tick(); chk("sim_b", 0,1,1,0,2'd1,0);
        INTR = 1;         tick(); chk("sim_c", 0,1,1,1,2'd1,0);
        INTR = 0;         tick(); chk("sim_d", 0,1,1,1,2'd1,0);
        INT_ACK = 1;      tick(); chk("ack_with_edge", 0,1,0,0,2'd2,0);
        I_SET = 1;        tick(); chk("pending_kept",  0,1,1,1,2'd2,0);
        FLG_C_SET = 1;    tick(); chk("c_set",         1,1,1,1,2'd2,0);

        // Overflow and unwinding
        INT_ACK = 1;      tick(); chk("overflow", 1,1,0,0,2'd2,1);
        FLG_C_CLR = 1; Z_IN = 0; FLG_Z_LD = 1; tick(); chk("clr_before_reti", 0,0,0,0,2'd2,1);
        RETI = 1;         tick(); chk("reti_top",      1,1,0,0,2'd1,1);
        RETI = 1; FLG_C_CLR = 1; tick(); chk("reti_over_clr", 1,0,0,0,2'd0,1);
        RETI = 1; I_SET = 1; tick(); chk("reti_empty_retie", 0,0,1,0,2'd0,1);

        // Build cnt=1 with a pending request, then reset asynchronously
        INTR = 1;         tick(); chk("rq_a", 0,0,1,0,2'd0,1);
        INTR = 0;         tick(); chk("rq_b", 0,0,1,0,2'd0,1);
                          tick(); chk("rq_c", 0,0,1,1,2'd0,1);
        INT_ACK = 1;      tick(); chk("ack_before_rst", 0,0,0,0,2'd1,1);
        INTR = 1;         tick();
        INTR = 0;         tick();
                          tick(); chk("pending_masked", 0,0,0,0,2'd1,1);
        I_SET = 1;        tick(); chk("pending_before_rst", 0,0,1,1,2'd1,1);
        tick();
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst", 0,0,0,0,2'd0,0);
        tick();
        RST = 1'b0;
        tick(); tick();
        I_SET = 1;        tick(); chk("no_req_after_rst", 0,0,1,0,2'd0,0);

        repeat (3) @(negedge CLK);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flag_int_unit.md
Name: flag_int_unit

Overview:
- Consumer side of the ALU flag interface. Registers the ALU carry and zero outputs into C/Z flags and feeds C_FLAG back to the ALU CIN input.
- Holds a shadow stack of flags for interrupt entry and return, plus the interrupt-enable flag.
- Synchronizes the external interrupt line and runs an INT_REQ/INT_ACK handshake with the control unit.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops on INTR (minimum 2).
- SHAD_DEPTH, 2: number of shadow {C,Z} entries, i.e. the supported interrupt nesting depth (minimum 1).

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- C_IN  in  1  ALU carry-out.
- Z_IN  in  1  ALU zero output.
- FLG_C_LD  in  1  load C_FLAG from C_IN.
- FLG_C_SET  in  1  set C_FLAG to 1.
- FLG_C_CLR  in  1  clear C_FLAG to 0.
- FLG_Z_LD  in  1  load Z_FLAG from Z_IN.
- I_SET  in  1  set I_FLAG to 1.
- I_CLR  in  1  clear I_FLAG to 0.
- RETI  in  1  one-cycle pulse: pop shadow stack into C/Z.
- INT_ACK  in  1  one-cycle pulse from control unit at interrupt entry.
- INTR  in  1  external interrupt, asynchronous to CLK.
- C_FLAG  out  1  carry flag; also drives ALU CIN.
- Z_FLAG  out  1  zero flag.
- I_FLAG  out  1  interrupt enable.
- INT_REQ  out  1  interrupt request to control unit.
- SHAD_CNT  out  $clog2(SHAD_DEPTH+1)  number of occupied shadow entries.
- SHAD_OVF  out  1  sticky overflow indicator.

Behaviour:
- Reset (asynchronous, RST=1): all outputs, synchronizer flops, the edge register, the pending latch and all shadow entries go to 0 immediately. Reset mid-handshake discards any pending request.
- C_FLAG update priority, highest first: INT_ACK (hold), RETI (pop), FLG_C_CLR, FLG_C_SET, FLG_C_LD; otherwise hold.
- Z_FLAG update priority, highest first: INT_ACK (hold), RETI (pop), FLG_Z_LD; otherwise hold.
- I_FLAG update priority, highest first: INT_ACK (clear), I_CLR, I_SET; otherwise hold.
  - I_SET/I_CLR are honoured in the same cycle as RETI, which is how RETIE and RETID are built.
- Synchronizer: INTR passes through a SYNC_STAGES flop chain s[0..N-1]. A further register prev holds s[N-1] delayed by one cycle.
  - A rising edge is detected when s[N-1]=1 and prev=0.
- Pending latch:
  - Set on a detected edge; cleared by an accepted INT_ACK.
  - If an edge and an accepted INT_ACK occur in the same cycle, set wins.
- INT_REQ = pending AND I_FLAG (combinational from registers).
- Request latency: INTR held high from before edge 1 sets pending at edge SYNC_STAGES+1. INT_REQ is high after that edge if I_FLAG=1.
- Handshake rules:
  - INT_ACK is accepted only when INT_REQ=1. When INT_REQ=0 it is ignored entirely: no push, and I_FLAG is unchanged.
  - Accepted INT_ACK, in one edge: push {C_FLAG,Z_FLAG}, clear I_FLAG, clear pending.
- Shadow stack (LIFO):
  - Push when SHAD_CNT < SHAD_DEPTH: write entry[SHAD_CNT], then SHAD_CNT+1.
  - Push when full: overwrite the top entry, leave SHAD_CNT unchanged, set SHAD_OVF.
  - RETI when SHAD_CNT > 0: C/Z are loaded from entry[SHAD_CNT-1], then SHAD_CNT-1.
  - RETI when SHAD_CNT = 0: C and Z are loaded with 0, SHAD_CNT stays 0.
- INT_ACK and RETI in the same cycle: INT_ACK wins and RETI is ignored. The control unit never issues both together.
- SHAD_OVF is sticky; only RST clears it.

Optional Feature:
- Macro: INTR_LEVEL_EN.
- Defined: interrupts are level-sensitive.
  - Pending follows the synchronized level s[N-1] every cycle; INT_ACK does not clear it.
  - INT_REQ = s[N-1] AND I_FLAG.
  - The prev register is removed.
  - Latency is SYNC_STAGES edges.
- Undefined: edge-detect behaviour as specified in Behaviour.

Test Plan:
- Flag load/priority: C_IN=1, FLG_C_LD=1 -> C_FLAG=1 next edge. Then FLG_C_SET=1 and FLG_C_CLR=1 together -> C_FLAG=0. Z_IN=1, FLG_Z_LD=1 -> Z_FLAG=1.
- Interrupt latency (SYNC_STAGES=2): with I_FLAG=1, INTR rises before edge 1 -> INT_REQ=1 after edge 3. INT_ACK pulse -> INT_REQ=0, I_FLAG=0, SHAD_CNT=1.
- Masked interrupt: I_FLAG=0, INTR pulse -> INT_REQ stays 0. I_SET at a later edge -> INT_REQ=1 the next cycle, because pending was retained.
- Nesting (SHAD_DEPTH=2): push {C,Z}={1,0}, then {0,1}, then {1,1} -> SHAD_OVF=1, SHAD_CNT=2. RETI -> C=1,Z=1, SHAD_CNT=1. RETI -> C=1,Z=0, SHAD_CNT=0. RETI -> C=0,Z=0.
- Ignored/simultaneous: INT_ACK with INT_REQ=0 -> no state change. A new edge in the same cycle as an accepted INT_ACK -> INT_REQ=0 that cycle (I_FLAG cleared), pending still 1; I_SET -> INT_REQ=1.
- Async reset mid-operation: assert RST between clock edges with SHAD_CNT=1, pending=1 -> all outputs 0 immediately, before the next CLK edge.
